// File: rtl/dice_pkg.sv
// Shared DICE types: CTA descriptor, CTA ID and per-slot lifecycle state.
package dice_pkg;

  localparam int DICE_NUM_MAX_CTA_PER_CORE = 4;

  typedef logic [7:0] dice_cta_id_t;

  typedef struct packed {
    dice_cta_id_t cta_id;
    logic [15:0]  start_pc;
    logic [7:0]   arg_base;
  } dice_cta_desc_t;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PENDING,
    SLOT_RUNNING,
    SLOT_RETIRING
  } slot_state_e;

endpackage

// File: rtl/cta_slot_manager_if.sv
// Grant, issue, completion and status signals of one per-core CTA slot table.
interface cta_slot_manager_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
);
  import dice_pkg::*;

  logic                           grant_valid;
  logic                           grant_ready;
  dice_cta_desc_t                 grant_ctx;
  logic                           exec_valid;
  logic                           exec_ready;
  dice_cta_desc_t                 exec_ctx;
  logic [SLOT_W-1:0]              exec_slot;
  logic                           exec_done_valid;
  logic [SLOT_W-1:0]              exec_done_slot;
  logic                           done_valid;
  logic                           done_ready;
  dice_cta_id_t                   done_cta_id;
  logic [$clog2(NUM_SLOTS+1)-1:0] occupancy;
  logic                           err_sticky;

  // Slot manager side.
  modport slave (
    input  grant_valid, grant_ctx, exec_ready, exec_done_valid, exec_done_slot, done_ready,
    output grant_ready, exec_valid, exec_ctx, exec_slot, done_valid, done_cta_id,
           occupancy, err_sticky
  );

  // Dispatcher / core side.
  modport master (
    output grant_valid, grant_ctx, exec_ready, exec_done_valid, exec_done_slot, done_ready,
    input  grant_ready, exec_valid, exec_ctx, exec_slot, done_valid, done_cta_id,
           occupancy, err_sticky
  );

endinterface

// File: rtl/cta_slot_manager.sv
// Per-core CTA slot table: holds granted contexts, issues them in grant order
// and returns completed CTA IDs in completion order.
`ifndef DICE_NUM_MAX_CTA_PER_CORE
`define DICE_NUM_MAX_CTA_PER_CORE dice_pkg::DICE_NUM_MAX_CTA_PER_CORE
`endif

module cta_slot_manager
  import dice_pkg::*;
#(
  parameter int NUM_SLOTS = `DICE_NUM_MAX_CTA_PER_CORE,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cta_slot_manager_if.slave   bus
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  slot_state_e       r_state     [NUM_SLOTS];
  slot_state_e       w_state_nxt [NUM_SLOTS];
  dice_cta_desc_t    r_ctx       [NUM_SLOTS];
  logic [SLOT_W-1:0] r_iq        [NUM_SLOTS];  // issue FIFO: slots in grant order
  logic [SLOT_W-1:0] r_rq        [NUM_SLOTS];  // retire FIFO: slots in completion order
  logic [SLOT_W-1:0] r_iq_rd, r_iq_wr, r_rq_rd, r_rq_wr;
  logic [CNT_W-1:0]  r_iq_cnt, r_rq_cnt, r_occ;
  logic              r_live;                   // low during reset so grants are refused
  logic              r_err;

  logic              w_any_free;
  logic [SLOT_W-1:0] w_free_idx;
  logic              w_grant_ready, w_grant_fire;
  logic              w_exec_valid, w_issue_fire;
  logic              w_done_valid, w_ret_fire;
  logic              w_done_ok, w_done_bad;
  logic [SLOT_W-1:0] w_iq_head, w_rq_head;

  function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
    return (int'(p) == NUM_SLOTS - 1) ? '0 : p + 1'b1;
  endfunction

  // Lowest-index FREE slot for the next grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_state[i] == SLOT_FREE) begin
        w_any_free = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  assign w_grant_ready = r_live && w_any_free;
  assign w_grant_fire  = bus.grant_valid && w_grant_ready;

  assign w_iq_head     = r_iq[r_iq_rd];
  assign w_exec_valid  = (r_iq_cnt != '0);
  assign w_issue_fire  = w_exec_valid && bus.exec_ready;

  assign w_rq_head     = r_rq[r_rq_rd];
  assign w_done_valid  = (r_rq_cnt != '0);
  assign w_ret_fire    = w_done_valid && bus.done_ready;

  // A completion is legal only for an in-range slot already RUNNING before this edge.
  assign w_done_ok  = bus.exec_done_valid && (int'(bus.exec_done_slot) < NUM_SLOTS) &&
                      (r_state[bus.exec_done_slot] == SLOT_RUNNING);
  assign w_done_bad = bus.exec_done_valid && !w_done_ok;

  // Slot lifecycle next state; the four events always target distinct slots.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) w_state_nxt[i] = r_state[i];
    if (w_grant_fire) w_state_nxt[w_free_idx]         = SLOT_PENDING;
    if (w_issue_fire) w_state_nxt[w_iq_head]          = SLOT_RUNNING;
    if (w_done_ok)    w_state_nxt[bus.exec_done_slot] = SLOT_RETIRING;
    if (w_ret_fire)   w_state_nxt[w_rq_head]          = SLOT_FREE;
  end

  // Slot state, FIFO pointers/counts, occupancy and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_state[i] <= SLOT_FREE;
      r_iq_rd  <= '0;
      r_iq_wr  <= '0;
      r_rq_rd  <= '0;
      r_rq_wr  <= '0;
      r_iq_cnt <= '0;
      r_rq_cnt <= '0;
      r_occ    <= '0;
      r_live   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NUM_SLOTS; i++) r_state[i] <= w_state_nxt[i];
      if (w_grant_fire) r_iq_wr <= ptr_inc(r_iq_wr);
      if (w_issue_fire) r_iq_rd <= ptr_inc(r_iq_rd);
      if (w_done_ok)    r_rq_wr <= ptr_inc(r_rq_wr);
      if (w_ret_fire)   r_rq_rd <= ptr_inc(r_rq_rd);
      r_iq_cnt <= r_iq_cnt + CNT_W'(w_grant_fire) - CNT_W'(w_issue_fire);
      r_rq_cnt <= r_rq_cnt + CNT_W'(w_done_ok)    - CNT_W'(w_ret_fire);
      r_occ    <= r_occ    + CNT_W'(w_grant_fire) - CNT_W'(w_ret_fire);
      r_live   <= 1'b1;
      r_err    <= r_err | w_done_bad;
    end
  end

  // Context and FIFO storage; outputs are masked while the matching FIFO is empty.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; nothing reads an entry before it is written.
    if (w_grant_fire) begin
      r_ctx[w_free_idx] <= bus.grant_ctx;
      r_iq[r_iq_wr]     <= w_free_idx;
    end
    if (w_done_ok) r_rq[r_rq_wr] <= bus.exec_done_slot;
  end

  assign bus.grant_ready = w_grant_ready;
  assign bus.exec_valid  = w_exec_valid;
  assign bus.exec_ctx    = w_exec_valid ? r_ctx[w_iq_head] : '0;
  assign bus.exec_slot   = w_exec_valid ? w_iq_head : '0;
  assign bus.done_valid  = w_done_valid;
  assign bus.done_cta_id = w_done_valid ? r_ctx[w_rq_head].cta_id : '0;
  assign bus.occupancy   = r_occ;
  assign bus.err_sticky  = r_err;

  a_no_iq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_grant_fire && !w_issue_fire && int'(r_iq_cnt) == NUM_SLOTS));
  a_no_rq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_done_ok && !w_ret_fire && int'(r_rq_cnt) == NUM_SLOTS));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(r_occ) <= NUM_SLOTS);
  a_exec_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (w_exec_valid && !bus.exec_ready) |=> ($stable(bus.exec_ctx) && $stable(bus.exec_slot)));

endmodule

// File: tb/tb_cta_slot_manager.sv
// Bench for cta_slot_manager (NUM_SLOTS=4): scoreboard queues plus scenario checks.
module tb_cta_slot_manager;
  import dice_pkg::*;

  localparam int NS = 4;

  typedef enum int {M_FREE, M_PEND, M_RUN, M_RET} mstate_e;
  typedef struct {
    logic [1:0]     slot;
    dice_cta_desc_t ctx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cta_slot_manager_if #(.NUM_SLOTS(NS)) bus ();
  cta_slot_manager #(.NUM_SLOTS(NS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int             total = 0;
  int             bad   = 0;
  mstate_e        m_st  [NS];
  dice_cta_desc_t m_ctx [NS];
  exp_t           q_exec[$];
  int             q_done[$];
  int             occ_m = 0;
  bit             err_m = 1'b0;
  bit             live_m = 1'b0;

  function automatic dice_cta_desc_t mk_ctx(input dice_cta_id_t id);
    dice_cta_desc_t d;
    d.cta_id   = id;
    d.start_pc = {8'hA5, id};
    d.arg_base = ~id;
    return d;
  endfunction

  task automatic set_in(input bit gv, input logic [7:0] id, input bit er,
                        input bit dv, input logic [1:0] ds, input bit dr);
    bus.grant_valid     = gv;
    bus.grant_ctx       = mk_ctx(id);
    bus.exec_ready      = er;
    bus.exec_done_valid = dv;
    bus.exec_done_slot  = ds;
    bus.done_ready      = dr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_st[i] = M_FREE;
    q_exec.delete();
    q_done.delete();
    occ_m  = 0;
    err_m  = 1'b0;
    live_m = 1'b0;
  endtask

  // One clock: score the handshakes seen now, advance the model, then check status after the edge.
  task automatic cycle();
    int   gslot;
    int   rs;
    bit   dn_ok;
    bit   any_free;
    exp_t e;
    gslot = -1;
    dn_ok = bus.exec_done_valid && (int'(bus.exec_done_slot) < NS) &&
            (m_st[bus.exec_done_slot] == M_RUN);
    if (bus.grant_valid && bus.grant_ready) begin
      for (int i = NS - 1; i >= 0; i--) if (m_st[i] == M_FREE) gslot = i;
      if (gslot < 0) begin
        total++; bad++;
        $display("FAIL grant_when_full: grant_ready=1 required=0");
      end
    end
    if (bus.exec_valid && bus.exec_ready) begin
      total++;
      if (q_exec.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: slot=%0d required=no issue", bus.exec_slot);
      end else begin
        e = q_exec.pop_front();
        if (bus.exec_slot !== e.slot || bus.exec_ctx !== e.ctx) begin
          bad++;
          $display("FAIL issue_order: slot=%0d ctx=%h required slot=%0d ctx=%h",
                   bus.exec_slot, bus.exec_ctx, e.slot, e.ctx);
        end
        m_st[e.slot] = M_RUN;
      end
    end
    if (bus.done_valid && bus.done_ready) begin
      total++;
      if (q_done.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: cta_id=%h required=no completion", bus.done_cta_id);
      end else begin
        rs = q_done.pop_front();
        if (bus.done_cta_id !== m_ctx[rs].cta_id) begin
          bad++;
          $display("FAIL done_order: cta_id=%h required=%h", bus.done_cta_id, m_ctx[rs].cta_id);
        end
        m_st[rs] = M_FREE;
        occ_m--;
      end
    end
    if (gslot >= 0) begin
      m_st[gslot]  = M_PEND;
      m_ctx[gslot] = bus.grant_ctx;
      e.slot = 2'(gslot);
      e.ctx  = bus.grant_ctx;
      q_exec.push_back(e);
      occ_m++;
    end
    if (dn_ok) begin
      m_st[bus.exec_done_slot] = M_RET;
      q_done.push_back(int'(bus.exec_done_slot));
    end else if (bus.exec_done_valid) begin
      err_m = 1'b1;
    end

    @(posedge clk);
    #1;
    live_m = 1'b1;

    any_free = 1'b0;
    for (int i = 0; i < NS; i++) if (m_st[i] == M_FREE) any_free = 1'b1;
    total++;
    if (bus.grant_ready !== (live_m && any_free)) begin
      bad++; $display("FAIL grant_ready: got=%b required=%b", bus.grant_ready, live_m && any_free);
    end
    total++;
    if (bus.exec_valid !== (q_exec.size() != 0)) begin
      bad++; $display("FAIL exec_valid: got=%b required=%b", bus.exec_valid, q_exec.size() != 0);
    end
    total++;
    if (bus.done_valid !== (q_done.size() != 0)) begin
      bad++; $display("FAIL done_valid: got=%b required=%b", bus.done_valid, q_done.size() != 0);
    end
    total++;
    if (bus.occupancy !== 3'(occ_m)) begin
      bad++; $display("FAIL occupancy: got=%0d required=%0d", bus.occupancy, occ_m);
    end
    total++;
    if (bus.err_sticky !== err_m) begin
      bad++; $display("FAIL err_sticky: got=%b required=%b", bus.err_sticky, err_m);
    end
    if (q_exec.size() != 0) begin
      total++;
      if (bus.exec_slot !== q_exec[0].slot) begin
        bad++; $display("FAIL exec_head: slot=%0d required=%0d", bus.exec_slot, q_exec[0].slot);
      end
    end
    if (q_done.size() != 0) begin
      total++;
      if (bus.done_cta_id !== m_ctx[q_done[0]].cta_id) begin
        bad++; $display("FAIL done_head: cta_id=%h required=%h", bus.done_cta_id, m_ctx[q_done[0]].cta_id);
      end
    end
  endtask

  // Issue and complete everything outstanding, within a fixed cycle budget.
  task automatic drain();
    for (int c = 0; c < 40 && !(occ_m == 0 && q_exec.size() == 0); c++) begin
      int rs;
      rs = -1;
      for (int i = 0; i < NS; i++) if (m_st[i] == M_RUN) rs = i;
      set_in(1'b0, 8'h00, 1'b1, rs >= 0, (rs >= 0) ? 2'(rs) : 2'd0, 1'b1);
      cycle();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    total++;
    if (bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL drain_timeout: occupancy=%0d required=0", bus.occupancy);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (bus.grant_ready !== 1'b0 || bus.exec_valid !== 1'b0 || bus.done_valid !== 1'b0 ||
        bus.occupancy !== 3'd0 || bus.err_sticky !== 1'b0 || bus.exec_slot !== 2'd0 ||
        bus.done_cta_id !== 8'h00) begin
      bad++;
      $display("FAIL %s: gr=%b ev=%b dv=%b occ=%0d err=%b slot=%0d id=%h required all zero",
               tag, bus.grant_ready, bus.exec_valid, bus.done_valid, bus.occupancy,
               bus.err_sticky, bus.exec_slot, bus.done_cta_id);
    end
  endtask

  task automatic test_reset();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    rst_n = 1'b1;
    total++;
    if (bus.grant_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release_gr: got=%b required=0", bus.grant_ready);
    end
    cycle();
    total++;
    if (bus.grant_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_gr: got=%b required=1", bus.grant_ready);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 5; k++) begin
      set_in(k < 4, 8'(k), 1'b1, 1'b0, 2'd0, 1'b0);
      total++;
      if (bus.exec_valid !== (k > 0)) begin
        bad++; $display("FAIL fill_exec_valid: cycle=%0d got=%b required=%b", k, bus.exec_valid, k > 0);
      end
      if (k > 0) begin
        total++;
        if (bus.exec_slot !== 2'(k - 1)) begin
          bad++; $display("FAIL fill_exec_slot: cycle=%0d got=%0d required=%0d", k, bus.exec_slot, k - 1);
        end
      end
      cycle();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    total++;
    if (bus.grant_ready !== 1'b0 || bus.occupancy !== 3'd4) begin
      bad++; $display("FAIL fill_full: gr=%b occ=%0d required gr=0 occ=4", bus.grant_ready, bus.occupancy);
    end
  endtask

  task automatic test_complete();
    logic [1:0] order [4];
    order = '{2'd2, 2'd0, 2'd3, 2'd1};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 8'h00, 1'b0, i < 4, (i < 4) ? order[i] : 2'd0, 1'b1);
      total++;
      if (i == 0) begin
        if (bus.done_valid !== 1'b0) begin
          bad++; $display("FAIL complete_early: done_valid=%b required=0", bus.done_valid);
        end
      end else if (bus.done_valid !== 1'b1 || bus.done_cta_id !== 8'(order[i - 1])) begin
        bad++; $display("FAIL complete_order: valid=%b id=%h required valid=1 id=%h",
                        bus.done_valid, bus.done_cta_id, 8'(order[i - 1]));
      end
      cycle();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    total++;
    if (bus.occupancy !== 3'd0 || bus.grant_ready !== 1'b1) begin
      bad++; $display("FAIL complete_empty: occ=%0d gr=%b required occ=0 gr=1", bus.occupancy, bus.grant_ready);
    end
  endtask

  task automatic test_backpressure();
    set_in(1'b1, 8'h10, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    set_in(1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (bus.exec_valid !== 1'b1 || bus.exec_slot !== 2'd0 || bus.exec_ctx !== mk_ctx(8'h10)) begin
        bad++; $display("FAIL bp_hold: valid=%b slot=%0d ctx=%h required valid=1 slot=0 ctx=%h",
                        bus.exec_valid, bus.exec_slot, bus.exec_ctx, mk_ctx(8'h10));
      end
      cycle();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    cycle();
    cycle();
    total++;
    if (bus.exec_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: exec_valid=%b required=0", bus.exec_valid);
    end
    drain();
  endtask

  task automatic test_retire_stall();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 8'h20 + 8'(k), 1'b1, 1'b0, 2'd0, 1'b0);
      cycle();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    cycle();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b0, 8'h00, 1'b0, 1'b1, 2'(k), 1'b0);
      cycle();
    end
    set_in(1'b1, 8'h30, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      total++;
      if (bus.grant_ready !== 1'b0) begin
        bad++; $display("FAIL stall_gr: got=%b required=0", bus.grant_ready);
      end
      cycle();
    end
    set_in(1'b1, 8'h30, 1'b0, 1'b0, 2'd0, 1'b1);
    total++;
    if (bus.grant_ready !== 1'b0 || bus.done_cta_id !== 8'h21) begin
      bad++; $display("FAIL stall_handshake: gr=%b id=%h required gr=0 id=21", bus.grant_ready, bus.done_cta_id);
    end
    cycle();
    set_in(1'b1, 8'h30, 1'b1, 1'b0, 2'd0, 1'b0);
    total++;
    if (bus.grant_ready !== 1'b1 || bus.occupancy !== 3'd3) begin
      bad++; $display("FAIL stall_reopen: gr=%b occ=%0d required gr=1 occ=3", bus.grant_ready, bus.occupancy);
    end
    cycle();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    total++;
    if (bus.exec_valid !== 1'b1 || bus.exec_slot !== 2'd1 || bus.exec_ctx.cta_id !== 8'h30) begin
      bad++; $display("FAIL stall_realloc: valid=%b slot=%0d id=%h required valid=1 slot=1 id=30",
                      bus.exec_valid, bus.exec_slot, bus.exec_ctx.cta_id);
    end
    cycle();
    drain();
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 8'h50 + 8'(k), 1'b1, 1'b0, 2'd0, 1'b0);
      cycle();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1);
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1);
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1);
    cycle();
    set_in(1'b1, 8'h60, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    // slot0 PENDING, slot1 FREE, slot2 RUNNING, slot3 RETIRING at the retire head
    set_in(1'b1, 8'h61, 1'b1, 1'b1, 2'd2, 1'b1);
    total++;
    if (bus.grant_ready !== 1'b1 || bus.exec_slot !== 2'd0 || bus.done_cta_id !== 8'h53 ||
        bus.occupancy !== 3'd3) begin
      bad++; $display("FAIL simul_setup: gr=%b slot=%0d id=%h occ=%0d required gr=1 slot=0 id=53 occ=3",
                      bus.grant_ready, bus.exec_slot, bus.done_cta_id, bus.occupancy);
    end
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    total++;
    if (bus.occupancy !== 3'd3 || bus.err_sticky !== 1'b0 || bus.exec_slot !== 2'd1 ||
        bus.exec_ctx.cta_id !== 8'h61 || bus.done_cta_id !== 8'h52) begin
      bad++; $display("FAIL simul_effect: occ=%0d err=%b slot=%0d eid=%h did=%h required occ=3 err=0 slot=1 eid=61 did=52",
                      bus.occupancy, bus.err_sticky, bus.exec_slot, bus.exec_ctx.cta_id, bus.done_cta_id);
    end
    drain();
  endtask

  task automatic test_errors();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle();
    total++;
    if (bus.err_sticky !== 1'b1 || bus.done_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL err_free_slot: err=%b dv=%b occ=%0d required err=1 dv=0 occ=0",
                      bus.err_sticky, bus.done_valid, bus.occupancy);
    end
    set_in(1'b1, 8'h70, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle();
    total++;
    if (bus.exec_valid !== 1'b1 || bus.exec_slot !== 2'd0 || bus.done_valid !== 1'b0 ||
        bus.occupancy !== 3'd1) begin
      bad++; $display("FAIL err_pending_slot: ev=%b slot=%0d dv=%b occ=%0d required ev=1 slot=0 dv=0 occ=1",
                      bus.exec_valid, bus.exec_slot, bus.done_valid, bus.occupancy);
    end
    // exec_done on the slot being issued this very cycle is still illegal
    set_in(1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    total++;
    if (bus.done_valid !== 1'b0) begin
      bad++; $display("FAIL err_same_cycle: done_valid=%b required=0", bus.done_valid);
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 8'h71, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    set_in(1'b1, 8'h72, 1'b0, 1'b1, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_immediate");
    model_reset();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    total++;
    if (bus.grant_ready !== 1'b1 || bus.occupancy !== 3'd0 || bus.done_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_after: gr=%b occ=%0d dv=%b required gr=1 occ=0 dv=0",
                      bus.grant_ready, bus.occupancy, bus.done_valid);
    end
    set_in(1'b1, 8'h80, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle();
    total++;
    if (bus.exec_slot !== 2'd0 || bus.exec_ctx !== mk_ctx(8'h80)) begin
      bad++; $display("FAIL reset_mid_regrant: slot=%0d ctx=%h required slot=0 ctx=%h",
                      bus.exec_slot, bus.exec_ctx, mk_ctx(8'h80));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_complete();
    test_backpressure();
    test_retire_stall();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 required finished");
    $fatal(1);
  end

endmodule

// File: doc/cta_slot_manager.md
Name: cta_slot_manager

Overview:
- Per-core CTA slot table that sits directly downstream of the CTA dispatcher, one instance per CGRA core.
- Accepts CTA grants and holds each granted context in a local slot. Hands contexts to the core execution front-end in grant order.
- Returns completed CTA IDs to the dispatcher in completion order. Its slot count matches the dispatcher's per-core credit count, so a correct dispatcher never sees the grant stalled for lack of a slot.

Parameters:
- NUM_SLOTS, default `DICE_NUM_MAX_CTA_PER_CORE: CTA contexts held concurrently; must be ≥1.
- SLOT_W, default $clog2(NUM_SLOTS) (min 1): slot index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- grant_valid  in  1  dispatcher grant valid
- grant_ready  out  1  at least one FREE slot
- grant_ctx  in  dice_pkg::dice_cta_desc_t  granted CTA context
- exec_valid  out  1  a PENDING CTA is offered to core
- exec_ready  in  1  core front-end accepts
- exec_ctx  out  dice_pkg::dice_cta_desc_t  context of offered CTA
- exec_slot  out  SLOT_W  slot index of offered CTA
- exec_done_valid  in  1  single-cycle pulse: slot finished; no backpressure
- exec_done_slot  in  SLOT_W  finished slot index
- done_valid  out  1  completion available to dispatcher
- done_ready  in  1  dispatcher accepts completion
- done_cta_id  out  dice_pkg::dice_cta_id_t  CTA ID of completed CTA
- occupancy  out  $clog2(NUM_SLOTS+1)  non-FREE slot count
- err_sticky  out  1  protocol violation seen since reset

Behaviour:
- Per-slot state: FREE → PENDING → RUNNING → RETIRING → FREE. Each slot stores its ctx.
- Reset (async): all slots FREE; both queues empty; grant_ready=0 while in reset; exec_valid=0, done_valid=0, occupancy=0, err_sticky=0, exec_slot=0, done_cta_id=0.
- After reset, grant_ready=1. grant_ready is combinational from registered slot state only (no dependence on done_ready).
- Grant fire (grant_valid&&grant_ready):
  - Lowest-index FREE slot becomes PENDING; ctx is captured.
  - Slot index is pushed to the issue FIFO (depth NUM_SLOTS, cannot overflow).
- Issue path:
  - exec_valid = issue FIFO non-empty; exec_ctx/exec_slot come from the FIFO head.
  - On exec_valid&&exec_ready: pop; slot → RUNNING.
  - Grant at cycle N → exec_valid earliest at N+1.
  - exec_ctx/exec_slot are held stable while exec_valid&&!exec_ready.
- Completion:
  - exec_done_valid with slot in RUNNING: slot → RETIRING; index pushed to the retire FIFO (depth NUM_SLOTS).
  - exec_done_valid targeting a slot not in RUNNING: ignored (no state change), err_sticky←1.
  - Index ≥ NUM_SLOTS is treated the same as a non-RUNNING slot.
- Done path:
  - done_valid = retire FIFO non-empty; done_cta_id = head slot's ctx.cta_id.
  - On done_valid&&done_ready: pop; slot → FREE.
  - exec_done at N → done_valid earliest at N+1.
  - Freed slot is visible on grant_ready at M+1, where M is the handshake cycle (no same-cycle reuse).
- grant_valid while grant_ready=0: no action, and no error (backpressure is legal).
- Simultaneous events: grant, issue, exec_done and done handshake may all occur in one cycle.
  - They act on distinct slots by construction.
  - Both FIFOs support push and pop in the same cycle.
  - occupancy updates by +grant_fire −done_fire.
- exec_done may target the slot that is being issued in the same cycle? Illegal: the slot is not yet RUNNING, so the event is ignored and err_sticky←1.
- Full: occupancy==NUM_SLOTS → grant_ready=0.
- Empty: both FIFOs empty → exec_valid=0 and done_valid=0.
- FIFO pointers wrap modulo NUM_SLOTS. A separate count distinguishes full from empty.
- Reset mid-operation discards all contexts; no completion is reported for them.
- Sim-only assertions:
  - No FIFO overflow.
  - occupancy ≤ NUM_SLOTS.
  - exec_ctx stable under backpressure.

Test Plan:
- NUM_SLOTS=4: four back-to-back grants with cta_id x=0..3, exec_ready=1 → exec_slot 0,1,2,3 on consecutive cycles starting one cycle after the first grant; grant_ready=0 after the 4th grant; occupancy=4.
- Full table, exec_done slots 2,0,3,1, done_ready=1 → done_cta_id x=2,0,3,1 in that order, each one cycle after its exec_done; occupancy returns to 0; grant_ready=1.
- exec_ready=0 for 5 cycles with 2 CTAs pending → exec_valid held high; exec_ctx/exec_slot stable; on release, issue is in grant order.
- done_ready=0 with 3 RETIRING slots → grant_ready stays 0 (with a 4th slot occupied); a single done handshake frees exactly one slot, and grant_ready=1 the next cycle, with allocation choosing that slot.
- Same cycle: grant to slot 1, issue of slot 0, exec_done slot 2, done handshake slot 3 → all four take effect; occupancy unchanged; no err.
- exec_done on a FREE slot, then on a PENDING slot → no state change, err_sticky=1. Assert rst_n low mid-run → all outputs go to reset values immediately; after release, grant_ready=1 and occupancy=0.
